// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N shift-add multiplier with start/busy/done handshake.
// Optional build macro MUL_ZERO_BYPASS_EN: zero operands finish in one cycle without running.

module nBitCarryLookAheadAdder #(
  parameter int unsigned n = 4
) (
  input  logic [n-1:0] i_a,
  input  logic [n-1:0] i_b,
  input  logic         i_cin,
  output logic [n:0]   o_total
);

  logic [n-1:0] w_g;
  logic [n-1:0] w_p;
  logic [n:0]   w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Each carry is expanded fully from generate/propagate terms, never from a lower carry.
  always_comb begin
    logic v_c;
    logic v_p;
    v_c    = 1'b0;
    v_p    = 1'b0;
    w_c    = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < int'(n); i++) begin
      v_c = w_g[i];
      v_p = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        v_c = v_c | (v_p & w_g[j]);
        v_p = v_p & w_p[j];
      end
      w_c[i+1] = v_c | (v_p & i_cin);
    end
  end

  assign o_total = {w_c[n], w_p ^ w_c[n-1:0]};

endmodule

module shift_add_multiplier #(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        r_state;
  logic [N-1:0]  r_m;
  logic [2*N:0]  r_p;
  logic [CntW-1:0] r_cnt;

  logic [N-1:0]  w_add_b;
  logic [N:0]    w_total;
  logic [2*N:0]  w_p_shift;
  logic          w_zero;

  assign w_add_b = r_p[0] ? r_m : '0;

  nBitCarryLookAheadAdder #(
    .n (N)
  ) u_adder (
    .i_a     (r_p[2*N-1:N]),
    .i_b     (w_add_b),
    .i_cin   (1'b0),
    .o_total (w_total)
  );

  // The adder carry lands in bit 2N-1 after the shift; the top bit is always refilled with 0.
  assign w_p_shift = r_p[0] ? {1'b0, w_total, r_p[N-1:1]} : {1'b0, r_p[2*N:1]};

`ifdef MUL_ZERO_BYPASS_EN
  assign w_zero = (a == '0) || (b == '0);
`else
  assign w_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_m     <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_m   <= a;
            r_p   <= {{(N + 1){1'b0}}, b};
            r_cnt <= '0;
            if (w_zero) begin
              r_state <= StDone;
              done    <= 1'b1;
              product <= '0;
            end else begin
              r_state <= StRun;
              busy    <= 1'b1;
            end
          end else begin
            r_state <= StIdle;
          end
        end
        StRun: begin
          r_p   <= w_p_shift;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CntW'(N - 1)) begin
            r_state <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= w_p_shift[2*N-1:0];
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: vector table, directed corner sequences,
// and random operands checked against a plain a*b reference.

module tb_shift_add_multiplier;

  localparam int unsigned N = 4;

`ifdef MUL_ZERO_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int n_checks;
  int n_fail;

  shift_add_multiplier #(
    .N (N)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [N-1:0]   va;
    logic [N-1:0]   vb;
    logic [2*N-1:0] vprod;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: latency from accepted start to the done cycle, and busy cycles.
  function automatic int ref_lat(input logic [N-1:0] x, input logic [N-1:0] y);
    if (Bypass && (x == 0 || y == 0)) return 1;
    return N + 1;
  endfunction

  function automatic int ref_busy(input logic [N-1:0] x, input logic [N-1:0] y);
    if (Bypass && (x == 0 || y == 0)) return 0;
    return N;
  endfunction

  task automatic launch(input logic [N-1:0] x, input logic [N-1:0] y);
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_and_check(input string name, input logic [N-1:0] x, input logic [N-1:0] y,
                               input logic [2*N-1:0] exp_prod);
    int lat;
    int bcnt;
    launch(x, y);
    wait_done(lat, bcnt);
    check({name, "_latency"}, 64'(lat), 64'(ref_lat(x, y)));
    check({name, "_busy_cycles"}, 64'(bcnt), 64'(ref_busy(x, y)));
    check({name, "_product"}, 64'(product), 64'(exp_prod));
    @(negedge clk);
    check({name, "_done_pulse"}, 64'(done), 64'd0);
    check({name, "_product_hold"}, 64'(product), 64'(exp_prod));
  endtask

  initial begin
    vec_t vecs[$];
    int   lat;
    int   bcnt;
    logic [N-1:0] ra;
    logic [N-1:0] rb;

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;

    vecs.push_back('{va: 4'd13, vb: 4'd11, vprod: 8'h8F});
    vecs.push_back('{va: 4'd15, vb: 4'd15, vprod: 8'hE1});
    vecs.push_back('{va: 4'd0,  vb: 4'd9,  vprod: 8'h00});
    vecs.push_back('{va: 4'd7,  vb: 4'd0,  vprod: 8'h00});
    vecs.push_back('{va: 4'd1,  vb: 4'd1,  vprod: 8'h01});
    vecs.push_back('{va: 4'd15, vb: 4'd1,  vprod: 8'h0F});
    vecs.push_back('{va: 4'd8,  vb: 4'd8,  vprod: 8'h40});
    vecs.push_back('{va: 4'd10, vb: 4'd12, vprod: 8'h78});

    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", 64'(product), 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vprod);
    end

    // Back-to-back: new start in the DONE cycle of 13x11.
    launch(4'd13, 4'd11);
    wait_done(lat, bcnt);
    check("b2b_first_product", 64'(product), 64'h8F);
    a     = 4'd6;
    b     = 4'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= int'(N); k++) begin
      @(negedge clk);
      check("b2b_hold_first", 64'(product), 64'h8F);
    end
    @(negedge clk);
    check("b2b_second_done", 64'(done), 64'd1);
    check("b2b_second_product", 64'(product), 64'h2A);

    // Start re-pulsed mid-RUN with different operands is ignored.
    launch(4'd9, 4'd5);
    repeat (2) @(negedge clk);
    a     = 4'd1;
    b     = 4'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bcnt);
    check("midrun_latency_rest", 64'(lat), 64'(N - 1));
    check("midrun_product", 64'(product), 64'h2D);

    // Asynchronous reset mid-RUN.
    launch(4'd13, 4'd11);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_done", 64'(done), 64'd0);
    check("async_rst_product", 64'(product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 2) @(negedge clk);
    check("post_rst_idle_done", 64'(done), 64'd0);
    check("post_rst_idle_busy", 64'(busy), 64'd0);
    run_and_check("post_rst_3x3", 4'd3, 4'd3, 8'd9);

    // Random operands against a*b.
    for (int t = 0; t < 40; t++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      launch(ra, rb);
      wait_done(lat, bcnt);
      check($sformatf("rand%0d_latency", t), 64'(lat), 64'(ref_lat(ra, rb)));
      check($sformatf("rand%0d_product(%0d*%0d)", t, ra, rb), 64'(product),
            64'(int'(ra) * int'(rb)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
